// File: rtl/mips_multicycle_ctrl_if.sv
// Bus between the multicycle control FSM and the MIPS datapath.
// The master side is the controller, the slave side is the datapath.
interface mips_multicycle_ctrl_if #(
  parameter int STATE_W = 4,
  parameter int PERF_W  = 32
);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               PCWrite;
  logic               Branch;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic [1:0]         PCSrc;
  logic [1:0]         ALUop;
  logic               ALUsrcA;
  logic [1:0]         ALUsrcB;
  logic               RegWrite;
  logic               RegDst;
  logic               halted;
  logic [STATE_W-1:0] state_dbg;
  logic [PERF_W-1:0]  cycle_cnt;
  logic [PERF_W-1:0]  instr_cnt;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSrc, ALUop, ALUsrcA, ALUsrcB, RegWrite, RegDst, halted,
           state_dbg, cycle_cnt, instr_cnt
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
           PCSrc, ALUop, ALUsrcA, ALUsrcB, RegWrite, RegDst, halted,
           state_dbg, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore main-control FSM for the MIPS-32 multicycle datapath (R, lw, sw, beq, j, addi).
// Optional perf counters enabled by defining MIPS_CTRL_PERF_EN.
module mips_multicycle_ctrl #(
  parameter int STATE_W = 4,
  parameter int PERF_W  = 32
) (
  input logic                 clk,
  input logic                 rst,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    IDLE   = STATE_W'(0),
    FETCH  = STATE_W'(1),
    DECODE = STATE_W'(2),
    MEMADR = STATE_W'(3),
    MEMRD  = STATE_W'(4),
    MEMWB  = STATE_W'(5),
    MEMWR  = STATE_W'(6),
    EXEC   = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9),
    JUMP   = STATE_W'(10),
    ADDIEX = STATE_W'(11),
    ADDIWB = STATE_W'(12),
    HALT   = STATE_W'(15)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   state_nx = FETCH;
      FETCH:  if (bus.mem_ready) state_nx = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_nx = EXEC;
          OP_LW, OP_SW: state_nx = MEMADR;
          OP_BEQ:       state_nx = BRANCH;
          OP_J:         state_nx = JUMP;
          OP_ADDI:      state_nx = ADDIEX;
          default:      state_nx = HALT;
        endcase
      end
      MEMADR: state_nx = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (bus.mem_ready) state_nx = MEMWB;
      MEMWB:  state_nx = FETCH;
      MEMWR:  if (bus.mem_ready) state_nx = FETCH;
      EXEC:   state_nx = ALUWB;
      ALUWB:  state_nx = FETCH;
      BRANCH: state_nx = FETCH;
      JUMP:   state_nx = FETCH;
      ADDIEX: state_nx = ADDIWB;
      ADDIWB: state_nx = FETCH;
      HALT:   state_nx = HALT;
      default: state_nx = HALT;
    endcase
  end

  // FETCH is the only state with Mealy terms: IR and PC load on the ready cycle.
  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.Branch   = 1'b0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.PCSrc    = 2'b00;
    bus.ALUop    = 2'b00;
    bus.ALUsrcA  = 1'b0;
    bus.ALUsrcB  = 2'b00;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 1'b0;
    bus.halted   = 1'b0;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUsrcB = 2'b01;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      DECODE: bus.ALUsrcB = 2'b11;
      MEMADR: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      EXEC: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUop   = 2'b10;
      end
      ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BRANCH: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUop   = 2'b01;
        bus.PCSrc   = 2'b01;
        bus.Branch  = 1'b1;
      end
      JUMP: begin
        bus.PCSrc   = 2'b10;
        bus.PCWrite = 1'b1;
      end
      ADDIEX: begin
        bus.ALUsrcA = 1'b1;
        bus.ALUsrcB = 2'b10;
      end
      ADDIWB: bus.RegWrite = 1'b1;
      HALT:   bus.halted   = 1'b1;
      default: ;
    endcase
  end

  assign bus.state_dbg = state;

`ifdef MIPS_CTRL_PERF_EN
  logic [PERF_W-1:0] cycle_q, instr_q;

  // An instruction retires when the FSM re-enters FETCH from any execution state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state != HALT) cycle_q <= cycle_q + PERF_W'(1);
      if (state_nx == FETCH && state != IDLE && state != FETCH)
        instr_q <= instr_q + PERF_W'(1);
    end
  end

  assign bus.cycle_cnt = cycle_q;
  assign bus.instr_cnt = instr_q;
`else
  assign bus.cycle_cnt = {PERF_W{1'b0}};
  assign bus.instr_cnt = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction phase model with
// random memory wait states, plus reset, halt and abort-in-MEMWR scenarios.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned m_cyc    = 0;
  int unsigned m_ins    = 0;
  string       phase    = "init";

`ifdef MIPS_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  mips_multicycle_ctrl_if #(.STATE_W(4), .PERF_W(32)) bus ();

  mips_multicycle_ctrl #(.STATE_W(4), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] exp_out(int st, logic mr);
    logic pcw = 0, br = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0;
    logic asa = 0, rw = 0, rd = 0, hl = 0;
    logic [1:0] pcs = 0, aop = 0, asb = 0;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rd = 1; rw = 1; end
      9:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      10: begin pcs = 2'b10; pcw = 1; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      15: hl = 1;
      default: ;
    endcase
    return {pcw, br, iord, mrd, mwr, irw, m2r, pcs, aop, asa, asb, rw, rd, hl};
  endfunction

  function automatic logic [16:0] obs_out();
    return {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.PCSrc, bus.ALUop, bus.ALUsrcA,
            bus.ALUsrcB, bus.RegWrite, bus.RegDst, bus.halted};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, expv);
    end
  endtask

  // One clock cycle: drive mem_ready, check the expected state and outputs, advance.
  task automatic step(int st, logic mr);
    bus.mem_ready = mr;
    #1;
    chk("state", 64'(bus.state_dbg), 64'(st));
    chk("outs", 64'(obs_out()), 64'(exp_out(st, mr)));
    chk("cycle_cnt", 64'(bus.cycle_cnt), PERF ? 64'(m_cyc) : 64'd0);
    chk("instr_cnt", 64'(bus.instr_cnt), PERF ? 64'(m_ins) : 64'd0);
    if (st != 15) m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_state", 64'(bus.state_dbg), 64'd0);
      chk("rst_outs", 64'(obs_out()), 64'd0);
      chk("rst_cycle", 64'(bus.cycle_cnt), 64'd0);
      chk("rst_instr", 64'(bus.instr_cnt), 64'd0);
    end
    m_cyc = 0;
    m_ins = 0;
    rst = 1'b0;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Walks one instruction through its phase list; memory phases last wait+1 cycles.
  task automatic run_instr(logic [5:0] op, int wf, int wm);
    bus.opcode = op;
    repeat (wf) step(1, 1'b0);
    step(1, 1'b1);
    step(2, rnd_bit());
    case (op)
      6'b000000: begin step(7, rnd_bit()); step(8, rnd_bit()); end
      6'b100011: begin
        step(3, rnd_bit());
        repeat (wm) step(4, 1'b0);
        step(4, 1'b1);
        step(5, rnd_bit());
      end
      6'b101011: begin
        step(3, rnd_bit());
        repeat (wm) step(6, 1'b0);
        step(6, 1'b1);
      end
      6'b000100: step(9, rnd_bit());
      6'b000010: step(10, rnd_bit());
      6'b001000: begin step(11, rnd_bit()); step(12, rnd_bit()); end
      default: return;
    endcase
    m_ins++;
  endtask

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                6'b000100, 6'b000010, 6'b001000};

  initial begin
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    phase = "reset";
    do_reset();
    step(0, 1'b1);

    phase = "rtype";
    run_instr(6'b000000, 0, 0);
    phase = "lw_wait3";
    run_instr(6'b100011, 0, 3);
    phase = "beq";
    run_instr(6'b000100, 0, 0);
    phase = "jump";
    run_instr(6'b000010, 0, 0);
    phase = "sw_fetchwait";
    run_instr(6'b101011, 2, 1);
    phase = "addi";
    run_instr(6'b001000, 1, 0);

    phase = "random";
    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));

    phase = "halt";
    run_instr(6'b111111, 0, 0);
    repeat (20) begin
      bus.opcode = 6'($urandom);
      step(15, rnd_bit());
    end

    phase = "recover";
    do_reset();
    step(0, 1'b0);
    run_instr(6'b100011, 1, 2);

    phase = "abort_memwr";
    bus.opcode = 6'b101011;
    step(1, 1'b1);
    step(2, 1'b0);
    step(3, 1'b0);
    step(6, 1'b0);
    do_reset();
    step(0, 1'b0);
    run_instr(6'b000000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
